// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, prescaled sampling and a
// STABLE_N-sample agreement filter producing a clean level and edge pulses.
module button_debounce #(
  parameter int unsigned bitW     = 20,
  parameter int unsigned STABLE_N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic unstable
);

  logic                sync1_q, sync2_q;
  logic [bitW-1:0]     presc_q, presc_d;
  logic [STABLE_N-1:0] hist_q, hist_d, hist_next;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                tick;

  assign tick      = &presc_q;
  assign hist_next = {hist_q[STABLE_N-2:0], sync2_q};

  always_comb begin
    presc_d = presc_q + bitW'(1);
    hist_d  = hist_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      hist_d = hist_next;
      // Decide on the history including this tick's sample, so the level
      // moves on the same edge that completes a uniform run.
      if ((&hist_next) && !level_q) begin
        level_d = 1'b1;
        rise_d  = 1'b1;
      end else if (!(|hist_next) && level_q) begin
        level_d = 1'b0;
        fall_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      presc_q <= '0;
      hist_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      hist_q  <= hist_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign unstable = !((&hist_q) || !(|hist_q));

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues expected pulses and
// output snapshots; a negedge monitor pops and compares them.
module tb_button_debounce;

  localparam int unsigned BitW    = 1;
  localparam int unsigned StableN = 4;
  localparam int          Period  = 1 << BitW;
  localparam int          LatMin  = 2 + (StableN - 1) * Period + 1;
  localparam int          LatMax  = 2 + StableN * Period;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic level, rise, fall, unstable;

  button_debounce #(
    .bitW    (BitW),
    .STABLE_N(StableN)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .btn_in  (btn_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .unstable(unstable)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic is_rise;
    int   start;
  } ev_t;

  typedef struct {
    int         at;
    int         tag;
    logic [3:0] mask;
    logic [3:0] val;
  } snap_t;

  ev_t   exp_q[$];
  snap_t snap_q[$];
  int    ntag = 0;
  logic  done = 1'b0;

  // Stand-in for the 7-segment counter's countup input.
  logic        hook_en = 1'b0;
  logic [3:0]  cnt7;
  logic [15:0] seen;
  int          hook_rises;
  always @(posedge clock) begin
    if (!hook_en) begin
      cnt7       <= 4'd0;
      seen       <= 16'h0001;
      hook_rises <= 0;
    end else if (rise) begin
      cnt7             <= cnt7 + 4'd1;
      seen[cnt7+4'd1]  <= 1'b1;
      hook_rises       <= hook_rises + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  always @(negedge clock) begin : mon
    ev_t        e;
    snap_t      s;
    logic [3:0] o;
    int         lat;
    o = {level, rise, fall, unstable};
    if (rise || fall) begin
      tests++;
      if (rise && fall) begin
        fails++;
        $display("FAIL both_pulses cyc=%0d got rise=%0b fall=%0b want not both", cyc, rise, fall);
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse cyc=%0d got rise=%0b fall=%0b want none", cyc, rise, fall);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - e.start;
        tests++;
        if (rise != e.is_rise) begin
          fails++;
          $display("FAIL pulse_kind cyc=%0d got rise=%0b want rise=%0b", cyc, rise, e.is_rise);
        end
        tests++;
        if (lat < LatMin || lat > LatMax) begin
          fails++;
          $display("FAIL pulse_latency cyc=%0d got %0d want %0d..%0d", cyc, lat, LatMin, LatMax);
        end
        tests++;
        if (level != e.is_rise) begin
          fails++;
          $display("FAIL pulse_level cyc=%0d got %0b want %0b", cyc, level, e.is_rise);
        end
      end
    end
    while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
      s = snap_q.pop_front();
      tests++;
      if ((o & s.mask) != (s.val & s.mask)) begin
        fails++;
        $display("FAIL snap%0d cyc=%0d got {lvl,rise,fall,unst}=%b want %b mask %b",
                 s.tag, cyc, o, s.val, s.mask);
      end
    end
    if (done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL missing_pulses got %0d outstanding want 0", exp_q.size());
      end
      tests++;
      if (snap_q.size() != 0) begin
        fails++;
        $display("FAIL missing_snaps got %0d outstanding want 0", snap_q.size());
      end
      tests++;
      if (hook_rises != 16) begin
        fails++;
        $display("FAIL hook_count got %0d want 16", hook_rises);
      end
      tests++;
      if (seen != 16'hFFFF || cnt7 != 4'd0) begin
        fails++;
        $display("FAIL hook_digits got seen=%h cnt=%0d want seen=ffff cnt=0", seen, cnt7);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic snap(input int dt, input logic [3:0] mask, input logic [3:0] val);
    snap_q.push_back('{cyc + dt, ntag, mask, val});
    ntag++;
  endtask

  task automatic expect_ev(input logic is_rise);
    exp_q.push_back('{is_rise, cyc});
  endtask

  // Bouncy edge ending at value v: v,~v,v every 2 cycles, then held.
  task automatic bouncy(input logic v, input int hold);
    btn_in = v;
    step(2);
    btn_in = ~v;
    step(2);
    btn_in = v;
    expect_ev(v);
    step(hold);
  endtask

  initial begin
    // Reset with button low.
    snap(4, 4'b1111, 4'b0000);
    step(5);
    reset = 1'b0;
    step(10);
    snap(1, 4'b1111, 4'b0000);
    step(1);

    // Clean press.
    btn_in = 1'b1;
    expect_ev(1'b1);
    snap(5, 4'b1001, 4'b0001);
    snap(LatMax + 2, 4'b1111, 4'b1000);
    step(20);

    // Clean release.
    btn_in = 1'b0;
    expect_ev(1'b0);
    snap(LatMax + 2, 4'b1111, 4'b0000);
    step(20);

    // Bounce 1,0,1,0 then settle high: one rise only.
    btn_in = 1'b1;
    step(2);
    btn_in = 1'b0;
    step(2);
    btn_in = 1'b1;
    step(2);
    btn_in = 1'b0;
    step(2);
    btn_in = 1'b1;
    expect_ev(1'b1);
    snap(LatMin - 2, 4'b1000, 4'b0000);
    snap(LatMax + 2, 4'b1111, 4'b1000);
    step(20);

    // One-cycle low glitch while pressed: no fall.
    btn_in = 1'b0;
    step(1);
    btn_in = 1'b1;
    snap(20, 4'b1111, 4'b1000);
    step(21);

    // Release.
    btn_in = 1'b0;
    expect_ev(1'b0);
    step(20);

    // Reset after two qualifying samples; full requalification afterwards.
    btn_in = 1'b1;
    step(6);
    reset = 1'b1;
    snap(1, 4'b1111, 4'b0000);
    step(3);
    reset = 1'b0;
    expect_ev(1'b1);
    snap(LatMin - 1, 4'b1000, 4'b0000);
    snap(LatMax + 2, 4'b1111, 4'b1000);
    step(20);
    btn_in = 1'b0;
    expect_ev(1'b0);
    step(20);

    // Counter hookup over 16 bouncy presses.
    hook_en = 1'b1;
    step(2);
    for (int i = 0; i < 16; i++) begin
      bouncy(1'b1, 16);
      bouncy(1'b0, 16);
    end
    step(4);
    done = 1'b1;
    step(5);
    $display("FAIL monitor_timeout cyc=%0d", cyc);
    $fatal(1, "monitor did not finish");
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Upstream conditioning stage for push-button inputs feeding the 7-segment counter's count-enable.
- Synchronises a raw asynchronous button level and filters contact chatter by periodic sampling.
- Emits a clean debounced level plus single-cycle rise/fall pulses; the rise pulse drives the counter's countup directly.
- Prescaler width is parameterised so benches can shrink it to 1 for fast simulation.

Parameters:
- bitW, 20, prescaler width; one sample tick every 2^bitW clocks (about 10.5 ms at 100 MHz); legal range >= 1.
- STABLE_N, 4, consecutive identical samples required to change the debounced level; legal range >= 2.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw button level, asynchronous to clock.
- level  output  1  debounced button level.
- rise  output  1  one-cycle pulse when level goes 0->1.
- fall  output  1  one-cycle pulse when level goes 1->0.
- unstable  output  1  high while the sample history is not uniform.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset: on any clock edge with reset=1, all state clears and takes priority over every other event, including mid-filter.
  - sync1, sync2, prescaler, hist, level, rise, fall all go to 0.
  - unstable=0.
- Synchroniser: two flops.
  - sync1 <= btn_in; sync2 <= sync1.
  - Only sync2 is used downstream.
- Prescaler: bitW-bit free-running up-counter, wraps from all-ones to 0.
  - tick = (counter == all-ones), combinational.
  - First tick occurs 2^bitW-1 cycles after reset deasserts; then one tick every 2^bitW cycles.
- History: STABLE_N-bit shift register, hist <= {hist[STABLE_N-2:0], sync2} on tick only. Held otherwise.
- Decision, on a tick edge, using next = {hist[STABLE_N-2:0], sync2}:
  - next all ones and level=0: level<=1, rise<=1.
  - next all zeros and level=1: level<=0, fall<=1.
  - Otherwise level holds.
- rise and fall are registered and cleared on every non-decision cycle. Each is high for exactly one cycle, coincident with the first cycle level shows its new value. rise and fall are never high together.
- unstable = hist not all-equal, combinational from registered hist.
- Latency: from a btn_in change to level is between 2+(STABLE_N-1)*2^bitW+1 and 2+STABLE_N*2^bitW cycles, depending on tick phase.
- Glitch rejection: any excursion that breaks a run of STABLE_N equal samples restarts qualification. A change seen at fewer than STABLE_N consecutive ticks never reaches level.
- Input held high through reset:
  - level rises only after STABLE_N ticks following reset release.
  - rise pulses once.
- No enable input. No metastability handling beyond the two-flop synchroniser.

Test Plan:
- bitW=1, STABLE_N=4: reset 5 cycles with btn_in=0 -> level, rise, fall, unstable all 0. Ticks on the 2nd, 4th, 6th... cycles after release.
- Press: btn_in 0->1 held 20 cycles -> level rises exactly at the 4th tick after sync2=1. rise high 1 cycle, fall stays 0. unstable high from the 1st to the 3rd sampled 1.
- Bounce: btn_in toggles 1,0,1,0 every 2 cycles for 10 cycles, then stays 1 -> no rise during the bounce. One rise after 4 clean ticks; exactly 1 rise in total.
- Release: from level=1, btn_in->0 held -> fall pulses once, level=0 at the 4th qualifying tick. A 1-cycle 0 glitch instead produces no fall.
- Reset mid-qualification: assert reset after 2 of 4 ticks of a press -> all outputs 0 next edge. After release with btn_in still 1, a full 4 ticks are needed before rise.
- Hookup: drive count7seg countup from rise over 16 bouncy presses -> counter advances exactly 16 (shows 0 to F once each).
